mem_arbiter: RTL and testbench

// Shares the single byte-wide RAM port between instruction fetch (IF) and the MEM stage.

---
 rtl/mem_arbiter_pkg.sv | 22 ++
 rtl/mem_arbiter_byte_seq.sv | 63 ++++++
 rtl/mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the byte-serial RAM port arbiter: FSM states, owners,
// access lengths and the length normaliser used at grant time.
package mem_arbiter_pkg;

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_RD   = 2'd1;
    localparam logic [1:0] ARB_WR   = 2'd2;
    localparam logic [1:0] ARB_DONE = 2'd3;

    localparam logic OWNER_IF  = 1'b0;
    localparam logic OWNER_MEM = 1'b1;

    localparam logic [2:0] LEN_B = 3'd1;
    localparam logic [2:0] LEN_H = 3'd2;
    localparam logic [2:0] LEN_W = 3'd4;

    // Anything other than a byte or halfword access is serviced as a full word.
    function automatic logic [2:0] norm_len(input logic [2:0] len);
        return (len == LEN_B || len == LEN_H) ? len : LEN_W;
    endfunction

endpackage

// File: rtl/mem_arbiter_byte_seq.sv
// Byte sequencer: holds base/len/count of the granted access and derives the
// RAM address, end-of-access flags and the lane indices for write and capture.
module mem_arbiter_byte_seq
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [2:0]        len_i,
    input  logic              step_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              issue_o,
    output logic              wr_last_o,
    output logic              rd_last_o,
    output logic              cap_valid_o,
    output logic [1:0]        cap_lane_o,
    output logic [1:0]        cur_lane_o
);

    logic [ADDR_W-1:0] base_q, base_d;
    logic [2:0]        len_q, len_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        prev_cnt;

    always_comb begin
        base_d = base_q;
        len_d  = len_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            base_d = base_i;
            len_d  = len_i;
            cnt_d  = 3'd0;
        end else if (step_i) begin
            cnt_d = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q <= '0;
            len_q  <= LEN_W;
            cnt_q  <= 3'd0;
        end else begin
            base_q <= base_d;
            len_q  <= len_d;
            cnt_q  <= cnt_d;
        end
    end

    // The byte returned this cycle belongs to the address issued one count earlier.
    assign prev_cnt    = cnt_q - 3'd1;
    assign addr_o      = base_q + ADDR_W'(cnt_q);
    assign issue_o     = cnt_q < len_q;
    assign wr_last_o   = cnt_q == (len_q - 3'd1);
    assign rd_last_o   = cnt_q == len_q;
    assign cap_valid_o = cnt_q != 3'd0;
    assign cap_lane_o  = prev_cnt[1:0];
    assign cur_lane_o  = cnt_q[1:0];

endmodule

// File: rtl/mem_arbiter.sv
// Shares one byte-wide RAM port between instruction fetch and the MEM stage,
// serialising 1/2/4-byte accesses and assembling little-endian read data.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter bit MEM_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_done_o,
    output logic [31:0]       if_inst_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [2:0]        mem_len_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    output logic              mem_done_o,
    output logic [31:0]       mem_rdata_o,
    input  logic              flush_i,
    output logic              busy_o,
    input  logic [7:0]        ram_din_i,
    output logic [7:0]        ram_dout_o,
    output logic [ADDR_W-1:0] ram_a_o,
    output logic              ram_wr_o
);

    logic [1:0]  state_q, state_d;
    logic        owner_q, owner_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] asm_q, asm_d;
    logic [31:0] asm_cap;
    logic [31:0] if_inst_q, if_inst_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;

    logic              seq_load, seq_step;
    logic [ADDR_W-1:0] seq_base;
    logic [2:0]        seq_len;
    logic [ADDR_W-1:0] seq_addr;
    logic              seq_issue, seq_wr_last, seq_rd_last, seq_cap_valid;
    logic [1:0]        seq_cap_lane, seq_cur_lane;

    logic       if_ok, grant_mem, grant_if;
    logic [7:0] wlane [4];

    mem_arbiter_byte_seq #(
        .ADDR_W(ADDR_W)
    ) u_seq (
        .clk        (clk),
        .rst        (rst),
        .load_i     (seq_load),
        .base_i     (seq_base),
        .len_i      (seq_len),
        .step_i     (seq_step),
        .addr_o     (seq_addr),
        .issue_o    (seq_issue),
        .wr_last_o  (seq_wr_last),
        .rd_last_o  (seq_rd_last),
        .cap_valid_o(seq_cap_valid),
        .cap_lane_o (seq_cap_lane),
        .cur_lane_o (seq_cur_lane)
    );

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign wlane[gi] = wdata_q[8*gi +: 8];
        assign asm_cap[8*gi +: 8] = (seq_cap_valid && seq_cap_lane == 2'(gi))
                                    ? ram_din_i : asm_q[8*gi +: 8];
    end

    // A fetch is never started while the branch flush is active.
    assign if_ok     = if_req_i && !flush_i;
    assign grant_mem = mem_req_i && (MEM_FIRST || !if_ok);
    assign grant_if  = if_ok && !grant_mem;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        wdata_d     = wdata_q;
        asm_d       = asm_q;
        if_inst_d   = if_inst_q;
        mem_rdata_d = mem_rdata_q;
        seq_load    = 1'b0;
        seq_step    = 1'b0;
        seq_base    = '0;
        seq_len     = LEN_W;
        case (state_q)
            ARB_IDLE: begin
                if (grant_mem) begin
                    seq_load = 1'b1;
                    seq_base = mem_addr_i;
                    seq_len  = norm_len(mem_len_i);
                    owner_d  = OWNER_MEM;
                    wdata_d  = mem_wdata_i;
                    asm_d    = '0;
                    state_d  = mem_we_i ? ARB_WR : ARB_RD;
                end else if (grant_if) begin
                    seq_load = 1'b1;
                    seq_base = if_addr_i;
                    seq_len  = LEN_W;
                    owner_d  = OWNER_IF;
                    asm_d    = '0;
                    state_d  = ARB_RD;
                end
            end
            ARB_RD: begin
                if (owner_q == OWNER_IF && flush_i) begin
                    state_d = ARB_IDLE;
                end else begin
                    seq_step = seq_issue;
                    asm_d    = asm_cap;
                    if (seq_rd_last) begin
                        state_d = ARB_DONE;
                        if (owner_q == OWNER_IF) begin
                            if_inst_d = asm_cap;
                        end else begin
                            mem_rdata_d = asm_cap;
                        end
                    end
                end
            end
            ARB_WR: begin
                seq_step = 1'b1;
                if (seq_wr_last) begin
                    state_d = ARB_DONE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            owner_q     <= OWNER_IF;
            wdata_q     <= '0;
            asm_q       <= '0;
            if_inst_q   <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            wdata_q     <= wdata_d;
            asm_q       <= asm_d;
            if_inst_q   <= if_inst_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign busy_o      = state_q != ARB_IDLE;
    assign if_done_o   = (state_q == ARB_DONE) && (owner_q == OWNER_IF) && !flush_i;
    assign mem_done_o  = (state_q == ARB_DONE) && (owner_q == OWNER_MEM);
    assign ram_wr_o    = state_q == ARB_WR;
    assign ram_a_o     = ((state_q == ARB_RD && seq_issue) || state_q == ARB_WR) ? seq_addr : '0;
    assign ram_dout_o  = ram_wr_o ? wlane[seq_cur_lane] : 8'h00;
    assign if_inst_o   = if_inst_q;
    assign mem_rdata_o = mem_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: byte RAM fixture, transaction-level model with a
// per-cycle compare process, and directed scenarios with literal expectations.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic        if_done_o;
    logic [31:0] if_inst_o;
    logic        mem_req_i = 1'b0;
    logic        mem_we_i = 1'b0;
    logic [2:0]  mem_len_i = 3'd4;
    logic [31:0] mem_addr_i = '0;
    logic [31:0] mem_wdata_i = '0;
    logic        mem_done_o;
    logic [31:0] mem_rdata_o;
    logic        flush_i = 1'b0;
    logic        busy_o;
    logic [7:0]  ram_din_i;
    logic [7:0]  ram_dout_o;
    logic [31:0] ram_a_o;
    logic        ram_wr_o;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // RAM fixture: 64 KiB, address modulo 2^16, one-cycle registered read.
    logic [7:0]  ram [65536];
    logic        pl_en = 1'b0;
    logic [15:0] pl_a = '0;
    logic [7:0]  pl_d = '0;

    // Model state: shadow memory and expected event queues.
    logic [7:0]  shadow [65536];
    logic [31:0] exp_wa [$];
    logic [7:0]  exp_wd [$];
    logic [31:0] exp_if [$];
    logic [31:0] exp_mem [$];

    mem_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .if_req_i   (if_req_i),
        .if_addr_i  (if_addr_i),
        .if_done_o  (if_done_o),
        .if_inst_o  (if_inst_o),
        .mem_req_i  (mem_req_i),
        .mem_we_i   (mem_we_i),
        .mem_len_i  (mem_len_i),
        .mem_addr_i (mem_addr_i),
        .mem_wdata_i(mem_wdata_i),
        .mem_done_o (mem_done_o),
        .mem_rdata_o(mem_rdata_o),
        .flush_i    (flush_i),
        .busy_o     (busy_o),
        .ram_din_i  (ram_din_i),
        .ram_dout_o (ram_dout_o),
        .ram_a_o    (ram_a_o),
        .ram_wr_o   (ram_wr_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pl_en) ram[pl_a] <= pl_d;
        else if (ram_wr_o) ram[ram_a_o[15:0]] <= ram_dout_o;
        ram_din_i <= ram[ram_a_o[15:0]];
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int model_len(input logic [2:0] l);
        if (l == 3'd1) return 1;
        if (l == 3'd2) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input int n);
        logic [31:0] v = '0;
        logic [31:0] ak;
        for (int k = 0; k < n; k++) begin
            ak = a + 32'(k);
            v[8*k +: 8] = shadow[ak[15:0]];
        end
        return v;
    endfunction

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_a = a; pl_d = d;
        shadow[a] = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // Waits for the owner's done pulse, then drops the request at the following edge.
    task automatic wait_done(input bit is_mem);
        int n = 0;
        while (1) begin
            @(negedge clk);
            if (is_mem ? mem_done_o : if_done_o) break;
            n++;
            if (n > 60) begin
                tests++; fails++;
                $display("FAIL %s_timeout: got no done, want done within 60 cycles", is_mem ? "mem" : "if");
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic if_op(input logic [31:0] a);
        exp_if.push_back(model_read(a, 4));
        if_addr_i = a; if_req_i = 1'b1;
        wait_done(1'b0);
        if_req_i = 1'b0;
    endtask

    task automatic mem_op(input bit we, input logic [2:0] len, input logic [31:0] a, input logic [31:0] wd);
        int n = model_len(len);
        logic [31:0] ak;
        if (we) begin
            for (int k = 0; k < n; k++) begin
                ak = a + 32'(k);
                exp_wa.push_back(ak);
                exp_wd.push_back(wd[8*k +: 8]);
                shadow[ak[15:0]] = wd[8*k +: 8];
            end
        end else begin
            exp_mem.push_back(model_read(a, n));
        end
        mem_we_i = we; mem_len_i = len; mem_addr_i = a; mem_wdata_i = wd; mem_req_i = 1'b1;
        wait_done(1'b1);
        mem_req_i = 1'b0;
    endtask

    // Compare process: every RAM write and every done pulse against the model.
    always @(negedge clk) begin
        if (ram_wr_o) begin
            if (exp_wa.size() == 0) begin
                check("unexpected_write", ram_a_o, 32'hFFFF_FFFF);
            end else begin
                check("write_addr", ram_a_o, exp_wa.pop_front());
                check("write_data", {24'h0, ram_dout_o}, {24'h0, exp_wd.pop_front()});
            end
        end
        if (mem_done_o) begin
            if (exp_mem.size() == 0 && mem_we_i == 1'b0)
                check("unexpected_mem_done", 32'd1, 32'd0);
            else if (mem_we_i == 1'b0)
                check("mem_rdata", mem_rdata_o, exp_mem.pop_front());
        end
        if (if_done_o) begin
            if (exp_if.size() == 0) check("unexpected_if_done", 32'd1, 32'd0);
            else check("if_inst", if_inst_o, exp_if.pop_front());
        end
        if (if_done_o && mem_done_o) check("both_done", 32'd1, 32'd0);
    end

    int mt, it;

    initial begin
        for (int i = 0; i < 65536; i++) shadow[i] = 8'h00;
        @(posedge clk); #1;
        preload(16'h1000, 8'h13); preload(16'h1001, 8'h05);
        preload(16'h1002, 8'h00); preload(16'h1003, 8'h00);
        preload(16'h2000, 8'h78); preload(16'h2001, 8'h56);
        preload(16'h2002, 8'h34); preload(16'h2003, 8'h12);
        preload(16'h0020, 8'h00); preload(16'h0021, 8'h00);
        preload(16'h0022, 8'h11); preload(16'h0023, 8'h22);
        preload(16'h0030, 8'h80); preload(16'h0031, 8'hFF);
        preload(16'h0032, 8'hFF); preload(16'h0033, 8'hFF);
        preload(16'hFFFE, 8'hAA); preload(16'hFFFF, 8'hBB);
        preload(16'h0000, 8'hCC); preload(16'h0001, 8'hDD);
        for (int i = 0; i < 4; i++) preload(16'h0040 + 16'(i), 8'h5A);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", {31'h0, busy_o}, 32'd0);
        check("rst_ram_wr", {31'h0, ram_wr_o}, 32'd0);
        check("rst_ram_a", ram_a_o, 32'd0);
        check("rst_ram_dout", {24'h0, ram_dout_o}, 32'd0);
        check("rst_dones", {30'h0, if_done_o, mem_done_o}, 32'd0);
        check("rst_if_inst", if_inst_o, 32'd0);
        check("rst_mem_rdata", mem_rdata_o, 32'd0);
        @(posedge clk); #1;

        // Fetch 0x1000: four read addresses, done pulse in cycle 5 after grant.
        fork
            if_op(32'h0000_1000);
            begin
                @(posedge clk);
                for (int c = 0; c < 7; c++) begin
                    @(negedge clk);
                    if (c < 4) begin
                        check($sformatf("t1_ram_a_c%0d", c), ram_a_o, 32'h1000 + 32'(c));
                        check($sformatf("t1_ram_wr_c%0d", c), {31'h0, ram_wr_o}, 32'd0);
                    end
                    check($sformatf("t1_if_done_c%0d", c), {31'h0, if_done_o}, (c == 5) ? 32'd1 : 32'd0);
                    if (c == 5) check("t1_if_inst", if_inst_o, 32'h0000_0513);
                    if (c == 6) check("t1_busy_idle", {31'h0, busy_o}, 32'd0);
                end
            end
        join

        // Halfword store to 0x20.
        fork
            mem_op(1'b1, 3'd2, 32'h20, 32'hAABB_CCDD);
            begin
                @(posedge clk);
                @(negedge clk);
                check("t2_c0", {ram_wr_o, 7'h0, ram_dout_o, ram_a_o[15:0]}, {1'b1, 7'h0, 8'hDD, 16'h0020});
                @(negedge clk);
                check("t2_c1", {ram_wr_o, 7'h0, ram_dout_o, ram_a_o[15:0]}, {1'b1, 7'h0, 8'hCC, 16'h0021});
                @(negedge clk);
                check("t2_c2", {30'h0, ram_wr_o, mem_done_o}, 32'd1);
                @(negedge clk);
                check("t2_c3_done", {31'h0, mem_done_o}, 32'd0);
            end
        join
        check("t2_ram", {ram[16'h20], ram[16'h21], ram[16'h22], ram[16'h23]}, 32'hDDCC_1122);

        mem_op(1'b0, 3'd2, 32'h20, 32'h0);
        check("t2_load_h", mem_rdata_o, 32'h0000_CCDD);

        // Simultaneous requests: MEM first, IF done exactly seven cycles later.
        mt = -1; it = -1;
        fork
            mem_op(1'b0, 3'd4, 32'h20, 32'h0);
            if_op(32'h0000_1000);
            begin
                for (int c = 0; c < 20; c++) begin
                    @(negedge clk);
                    if (mem_done_o) mt = c;
                    if (if_done_o) it = c;
                end
            end
        join
        @(posedge clk); #1;
        check("t3_mem_before_if", {31'h0, mt >= 0 && it > mt}, 32'd1);
        check("t3_if_gap", 32'(it - mt), 32'd7);
        check("t3_mem_rdata", mem_rdata_o, 32'h2211_CCDD);

        // Flush during fetch RD at cnt=2, then a clean fetch from 0x2000.
        if_addr_i = 32'h1000; if_req_i = 1'b1;
        @(posedge clk); @(posedge clk); @(posedge clk); #1;
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0; if_req_i = 1'b0;
        @(negedge clk);
        check("t4_busy_after_flush", {31'h0, busy_o}, 32'd0);
        check("t4_no_if_done", {31'h0, if_done_o}, 32'd0);
        @(posedge clk); #1;
        if_op(32'h0000_2000);
        check("t4_if_inst", if_inst_o, 32'h1234_5678);

        // Byte load with flush mid-access; upper lanes zero-filled.
        fork
            mem_op(1'b0, 3'd1, 32'h30, 32'h0);
            begin
                @(posedge clk); @(posedge clk); #1;
                flush_i = 1'b1;
                @(posedge clk); #1;
                flush_i = 1'b0;
            end
        join
        check("t5_mem_rdata", mem_rdata_o, 32'h0000_0080);

        // Illegal length 3 becomes a word; fetch across the address wrap.
        mem_op(1'b0, 3'd3, 32'h20, 32'h0);
        check("t7_len3_word", mem_rdata_o, 32'h2211_CCDD);
        if_op(32'hFFFF_FFFE);
        check("t7_wrap_fetch", if_inst_o, 32'hDDCC_BBAA);
        mem_op(1'b1, 3'd4, 32'h50, 32'hCAFE_F00D);
        mem_op(1'b0, 3'd4, 32'h50, 32'h0);
        check("t7_word_rt", mem_rdata_o, 32'hCAFE_F00D);

        // Reset during a word store: two bytes land, then everything clears.
        exp_wa.push_back(32'h40); exp_wd.push_back(8'h44);
        exp_wa.push_back(32'h41); exp_wd.push_back(8'h33);
        mem_we_i = 1'b1; mem_len_i = 3'd4; mem_addr_i = 32'h40;
        mem_wdata_i = 32'h1122_3344; mem_req_i = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("t6_wr_before_rst", {31'h0, ram_wr_o}, 32'd1);
        @(posedge clk); #1;
        mem_req_i = 1'b0;
        @(negedge clk);
        check("t6_rst_ram", {ram_wr_o, 7'h0, ram_dout_o, ram_a_o[15:0]}, 32'd0);
        check("t6_rst_flags", {29'h0, busy_o, if_done_o, mem_done_o}, 32'd0);
        check("t6_rst_if_inst", if_inst_o, 32'd0);
        check("t6_rst_mem_rdata", mem_rdata_o, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("t6_ram_partial", {ram[16'h40], ram[16'h41], ram[16'h42], ram[16'h43]}, 32'h4433_5A5A);

        check("left_writes", 32'(exp_wa.size()), 32'd0);
        check("left_if", 32'(exp_if.size()), 32'd0);
        check("left_mem", 32'(exp_mem.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
